// File: rtl/register_file_sb_if.sv
// register_file_sb_if: read, write and scoreboard signals of
// the register file, seen from decode/writeback (master) side.
interface register_file_sb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2
);
   logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]            rd_busy;
   logic [NUM_WR-1:0]            wr_en;
   logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
   logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
   logic [NUM_WR-1:0]            wr_clr;
   logic                         alloc_en;
   logic [ADDR_WIDTH-1:0]        alloc_addr;
   logic                         flush;
   logic                         any_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, wr_clr,
      output alloc_en, alloc_addr, flush,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, wr_clr,
      input  alloc_en, alloc_addr, flush,
      output rd_data, rd_busy, any_busy
   );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with same-cycle
// write bypass and a per-register busy scoreboard for RAW stalls.
module register_file_sb #(
   parameter int REG_COUNT      = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int NUM_RD         = 2,
   parameter int NUM_WR         = 2,
   parameter int BYPASS         = 1,
   parameter int CLEAR_ON_RESET = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   register_file_sb_if.slave bus
);

   localparam logic [ADDR_WIDTH:0] LIMIT =
      REG_COUNT[ADDR_WIDTH:0];

   // nonzero and backed by a real register
   function automatic logic valid_addr(
      input logic [ADDR_WIDTH-1:0] a
   );
      return (a != '0) && ({1'b0, a} < LIMIT);
   endfunction

   logic [DATA_WIDTH-1:0] mem [REG_COUNT];
   logic [REG_COUNT-1:0]  busy_q;
   logic [REG_COUNT-1:0]  busy_d;

   logic [ADDR_WIDTH-1:0] ra [NUM_RD];
   logic [ADDR_WIDTH-1:0] wa [NUM_WR];
   logic [DATA_WIDTH-1:0] wd [NUM_WR];
   logic [NUM_WR-1:0]     wr_ok;
   logic                  alloc_ok;

   logic [NUM_RD*DATA_WIDTH-1:0] rdata;
   logic [NUM_RD-1:0]            rbusy;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign ra[k] = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // a write port is live only out of reset and on a real register
   for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
      assign wa[i]    = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[i]    = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign wr_ok[i] = rst_n && bus.wr_en[i] && valid_addr(wa[i]);
   end

   assign alloc_ok = bus.alloc_en && valid_addr(bus.alloc_addr);

   if (CLEAR_ON_RESET != 0) begin : g_clr
      // storage update; reset wipes every register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int r = 0; r < REG_COUNT; r++) begin
               mem[r] <= '0;
            end
         end else begin
            for (int i = 0; i < NUM_WR; i++) begin
               if (wr_ok[i]) begin
                  mem[wa[i]] <= wd[i];
               end
            end
         end
      end
   end else begin : g_keep
      // storage update; contents survive reset, later port wins
      always_ff @(posedge clk) begin
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_ok[i]) begin
               mem[wa[i]] <= wd[i];
            end
         end
      end
   end

   // busy next-state: flush, then alloc, then clearing writes
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_ok[i] && bus.wr_clr[i]) begin
            busy_d[wa[i]] = 1'b0;
         end
      end
      if (alloc_ok) begin
         busy_d[bus.alloc_addr] = 1'b1;
      end
      if (bus.flush) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   // scoreboard register, cleared immediately by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // read ports: array or in-flight write data, plus busy flag
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (valid_addr(ra[k])) begin
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = mem[ra[k]];
            rbusy[k] = busy_q[ra[k]];
            if (BYPASS != 0) begin
               for (int i = 0; i < NUM_WR; i++) begin
                  if (wr_ok[i] && wa[i] == ra[k]) begin
                     rdata[k*DATA_WIDTH +: DATA_WIDTH] = wd[i];
                  end
               end
            end
         end
      end
   end

   assign bus.rd_data  = rdata;
   assign bus.rd_busy  = rbusy;
   assign bus.any_busy = |busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: two configurations (bypass+clear, and
// no-bypass/keep with 24 regs) checked against a bench model.
module tb_register_file_sb;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NR   = 2;
   localparam int NW   = 2;
   localparam int RC_A = 32;
   localparam int RC_B = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic [NR*AW-1:0] rd_addr = '0;
   logic [NW-1:0]    wr_en = '0;
   logic [NW*AW-1:0] wr_addr = '0;
   logic [NW*DW-1:0] wr_data = '0;
   logic [NW-1:0]    wr_clr = '0;
   logic             alloc_en = 1'b0;
   logic [AW-1:0]    alloc_addr = '0;
   logic             flush = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   register_file_sb_if #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)
   ) ifa ();
   register_file_sb_if #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)
   ) ifb ();

   assign ifa.rd_addr    = rd_addr;
   assign ifa.wr_en      = wr_en;
   assign ifa.wr_addr    = wr_addr;
   assign ifa.wr_data    = wr_data;
   assign ifa.wr_clr     = wr_clr;
   assign ifa.alloc_en   = alloc_en;
   assign ifa.alloc_addr = alloc_addr;
   assign ifa.flush      = flush;
   assign ifb.rd_addr    = rd_addr;
   assign ifb.wr_en      = wr_en;
   assign ifb.wr_addr    = wr_addr;
   assign ifb.wr_data    = wr_data;
   assign ifb.wr_clr     = wr_clr;
   assign ifb.alloc_en   = alloc_en;
   assign ifb.alloc_addr = alloc_addr;
   assign ifb.flush      = flush;

   register_file_sb #(
      .REG_COUNT(RC_A), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );

   register_file_sb #(
      .REG_COUNT(RC_B), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .CLEAR_ON_RESET(0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   always #5 clk = ~clk;

   logic [NR*DW-1:0] od [2];
   logic [NR-1:0]    ob [2];
   logic             oa [2];
   assign od[0] = ifa.rd_data;
   assign od[1] = ifb.rd_data;
   assign ob[0] = ifa.rd_busy;
   assign ob[1] = ifb.rd_busy;
   assign oa[0] = ifa.any_busy;
   assign oa[1] = ifb.any_busy;

   // ---------------- model ----------------
   logic [DW-1:0] mreg [2][32];
   bit            mk   [2][32];
   bit            mb   [2][32];

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 32; r++) begin
            mreg[d][r] = '0;
            mk[d][r] = 1'b0;
            mb[d][r] = 1'b0;
         end
      end
   end

   function automatic int rc(input int d);
      return (d == 0) ? RC_A : RC_B;
   endfunction

   function automatic int wa(input int i);
      return int'(wr_addr[i*AW +: AW]);
   endfunction

   function automatic logic [DW-1:0] wd(input int i);
      return wr_data[i*DW +: DW];
   endfunction

   function automatic int ra(input int k);
      return int'(rd_addr[k*AW +: AW]);
   endfunction

   function automatic bit next_busy(input int r, input bit cur);
      if (flush) return 1'b0;
      if (alloc_en && int'(alloc_addr) == r) return 1'b1;
      for (int i = 0; i < NW; i++) begin
         if (wr_en[i] && wr_clr[i] && wa(i) == r) return 1'b0;
      end
      return cur;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) begin
               mb[d][r] <= 1'b0;
               if (d == 0) begin
                  mreg[d][r] <= '0;
                  mk[d][r] <= 1'b1;
               end
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            for (int r = 1; r < rc(d); r++) begin
               mb[d][r] <= next_busy(r, mb[d][r]);
            end
            for (int i = 0; i < NW; i++) begin
               if (wr_en[i] && wa(i) != 0 && wa(i) < rc(d)) begin
                  mreg[d][wa(i)] <= wd(i);
                  mk[d][wa(i)] <= 1'b1;
               end
            end
         end
      end
   end

   function automatic void exp_read(
      input int d, input int a,
      output logic [DW-1:0] v, output bit kn, output bit b
   );
      v = '0;
      kn = 1'b1;
      b = 1'b0;
      if (a == 0 || a >= rc(d)) return;
      b = mb[d][a];
      if (d == 0 && rst_n) begin
         for (int i = NW - 1; i >= 0; i--) begin
            if (wr_en[i] && wa(i) == a) begin
               v = wd(i);
               return;
            end
         end
      end
      v = mreg[d][a];
      kn = mk[d][a];
   endfunction

   task automatic chk(
      input string nm, input logic [31:0] act, input logic [31:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      #2;
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            bit anyb;
            anyb = 1'b0;
            for (int r = 1; r < 32; r++) anyb = anyb | mb[d][r];
            chk($sformatf("%s_any_busy", d == 0 ? "a" : "b"),
                32'(oa[d]), 32'(anyb));
            for (int k = 0; k < NR; k++) begin
               logic [DW-1:0] v;
               bit kn;
               bit b;
               exp_read(d, ra(k), v, kn, b);
               chk($sformatf("%s_rd_busy%0d", d == 0 ? "a" : "b", k),
                   32'(ob[d][k]), 32'(b));
               if (kn) begin
                  chk($sformatf("%s_rd_data%0d", d == 0 ? "a" : "b", k),
                      od[d][k*DW +: DW], v);
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      wr_en = '0;
      wr_addr = '0;
      wr_data = '0;
      wr_clr = '0;
      alloc_en = 1'b0;
      alloc_addr = '0;
      flush = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      chk_on = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int r = 1; r < 32; r += 2) begin
         wr_en = 2'b11;
         wr_addr = {5'(r + 1), 5'(r)};
         wr_data = {2{32'hFFFF_FFFF}};
         rd_addr = {5'(r + 1), 5'(r)};
         @(negedge clk);
      end

      idle();
      alloc_en = 1'b1;
      alloc_addr = 5'd6;
      rd_addr = {5'd31, 5'd9};
      #1;
      chk("a_preload_x9", ifa.rd_data[31:0], 32'hFFFF_FFFF);
      chk("a_preload_x31", ifa.rd_data[63:32], 32'hFFFF_FFFF);
      chk("b_preload_x9", ifb.rd_data[31:0], 32'hFFFF_FFFF);
      chk("b_out_of_range", ifb.rd_data[63:32], 32'h0);

      @(negedge clk);
      idle();
      #1;
      chk("a_busy_pre_reset", 32'(ifa.any_busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("a_async_rd0", ifa.rd_data[31:0], 32'h0);
      chk("a_async_rd1", ifa.rd_data[63:32], 32'h0);
      chk("a_async_any", 32'(ifa.any_busy), 32'h0);
      chk("b_async_any", 32'(ifb.any_busy), 32'h0);
      chk("b_keep_x9", ifb.rd_data[31:0], 32'hFFFF_FFFF);
      @(negedge clk);
      rst_n = 1'b1;

      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd5};
      wr_data = {32'h0, 32'hDEAD_BEEF};
      rd_addr = {5'd5, 5'd5};
      #1;
      chk("a_bypass", ifa.rd_data[31:0], 32'hDEAD_BEEF);
      chk("b_old_value", ifb.rd_data[31:0], 32'hFFFF_FFFF);
      @(negedge clk);
      idle();
      #1;
      chk("b_after_edge", ifb.rd_data[31:0], 32'hDEAD_BEEF);
      chk("a_after_edge", ifa.rd_data[63:32], 32'hDEAD_BEEF);

      @(negedge clk);
      wr_en = 2'b11;
      wr_addr = {5'd7, 5'd7};
      wr_data = {32'h22, 32'h11};
      rd_addr = {5'd7, 5'd7};
      #1;
      chk("a_bypass_hi_port", ifa.rd_data[31:0], 32'h22);
      @(negedge clk);
      idle();
      #1;
      chk("a_x7_hi_port", ifa.rd_data[63:32], 32'h22);
      chk("b_x7_hi_port", ifb.rd_data[31:0], 32'h22);

      @(negedge clk);
      wr_en = 2'b11;
      wr_addr = '0;
      wr_data = {2{32'h1234}};
      alloc_en = 1'b1;
      alloc_addr = 5'd0;
      rd_addr = '0;
      #1;
      chk("a_x0_bypass", ifa.rd_data[31:0], 32'h0);
      @(negedge clk);
      idle();
      #1;
      chk("a_x0_busy", 32'(ifa.rd_busy), 32'h0);
      chk("b_x0_data", ifb.rd_data[31:0], 32'h0);
      chk("a_x0_any", 32'(ifa.any_busy), 32'h0);

      @(negedge clk);
      alloc_en = 1'b1;
      alloc_addr = 5'd3;
      rd_addr = {5'd3, 5'd3};
      #1;
      chk("a_alloc_not_yet", 32'(ifa.rd_busy), 32'h0);
      @(negedge clk);
      idle();
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {32'h0, 32'h33};
      #1;
      chk("a_alloc_seen", 32'(ifa.rd_busy), 32'h3);
      chk("b_alloc_seen", 32'(ifb.rd_busy), 32'h3);
      @(negedge clk);
      wr_data = {32'h0, 32'h34};
      wr_clr = 2'b01;
      #1;
      chk("a_hold_noclr", 32'(ifa.rd_busy), 32'h3);
      @(negedge clk);
      idle();
      #1;
      chk("a_busy_cleared", 32'(ifa.rd_busy), 32'h0);
      chk("b_busy_cleared", 32'(ifb.rd_busy), 32'h0);

      @(negedge clk);
      alloc_en = 1'b1;
      alloc_addr = 5'd3;
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {32'h0, 32'h35};
      wr_clr = 2'b01;
      @(negedge clk);
      idle();
      #1;
      chk("a_alloc_beats_clr", 32'(ifa.rd_busy), 32'h3);
      chk("a_x3_data", ifa.rd_data[31:0], 32'h35);

      @(negedge clk);
      alloc_en = 1'b1;
      alloc_addr = 5'd4;
      rd_addr = {5'd12, 5'd4};
      @(negedge clk);
      alloc_addr = 5'd9;
      @(negedge clk);
      alloc_addr = 5'd12;
      @(negedge clk);
      alloc_addr = 5'd30;
      @(negedge clk);
      flush = 1'b1;
      alloc_addr = 5'd15;
      rd_addr = {5'd30, 5'd12};
      #1;
      chk("a_busy_pre_flush", 32'(ifa.rd_busy), 32'h3);
      chk("b_busy_pre_flush", 32'(ifb.rd_busy), 32'h1);
      @(negedge clk);
      idle();
      rd_addr = {5'd15, 5'd4};
      #1;
      chk("a_flush_rd_busy", 32'(ifa.rd_busy), 32'h0);
      chk("a_flush_any", 32'(ifa.any_busy), 32'h0);
      chk("b_flush_any", 32'(ifb.any_busy), 32'h0);

      repeat (2) @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
